// File: rtl/mod_exp_sequencer.sv
// Left-to-right square-and-multiply sequencer computing R = M^E mod N by driving an external modular multiplier.
// Optional macro SKIP_LZ_EN: start the bit scan at the most significant 1 of E, skipping squarings of ACC=1.
module mod_exp_sequencer #(
  parameter int K     = 8,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [K-1:0]     M,
  input  logic [EXP_W-1:0] E,
  input  logic [K-1:0]     N,
  output logic             busy,
  output logic             done,
  output logic [K-1:0]     R,
  output logic             mm_start,
  output logic [K-1:0]     mm_A,
  output logic [K-1:0]     mm_B,
  output logic [K-1:0]     mm_N,
  input  logic             mm_done,
  input  logic [K-1:0]     mm_C
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SQ_REQ, S_SQ_WAIT, S_MUL_REQ, S_MUL_WAIT, S_NEXT, S_FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [K-1:0]     acc, base, mod, r_q;
  logic [EXP_W-1:0] exp_q;
  logic [IW-1:0]    idx;

`ifdef SKIP_LZ_EN
  function automatic logic [IW-1:0] msb_idx(input logic [EXP_W-1:0] e);
    logic [IW-1:0] m;
    m = '0;
    for (int b = 0; b < EXP_W; b++)
      if (e[b]) m = IW'(b);
    return m;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (mod <= K'(1) || exp_q == '0) state_nxt = S_FINISH;
        else                             state_nxt = S_SQ_REQ;
      end
      S_SQ_REQ:   state_nxt = S_SQ_WAIT;
      S_SQ_WAIT:  if (mm_done) state_nxt = exp_q[idx] ? S_MUL_REQ : S_NEXT;
      S_MUL_REQ:  state_nxt = S_MUL_WAIT;
      S_MUL_WAIT: if (mm_done) state_nxt = S_NEXT;
      S_NEXT:     state_nxt = (idx == '0) ? S_FINISH : S_SQ_REQ;
      S_FINISH:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Operand, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      base  <= '0;
      mod   <= '0;
      exp_q <= '0;
      idx   <= '0;
      r_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          base  <= M;
          exp_q <= E;
          mod   <= N;
          acc   <= K'(1);
          idx   <= IW'(EXP_W - 1);
        end
        S_LOAD: begin
          if (mod <= K'(1)) acc <= '0;
`ifdef SKIP_LZ_EN
          idx <= msb_idx(exp_q);
`endif
        end
        S_SQ_WAIT, S_MUL_WAIT: if (mm_done) acc <= mm_C;
        S_NEXT:   if (idx != '0) idx <= idx - IW'(1);
        S_FINISH: r_q <= acc;
        default: ;
      endcase
    end
  end

  // Operands come straight from ACC/BASE, which cannot change before mm_done is taken
  always_comb begin
    mm_start = 1'b0;
    mm_A     = '0;
    mm_B     = '0;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    R        = r_q;
    case (state)
      S_SQ_REQ, S_SQ_WAIT: begin
        mm_start = (state == S_SQ_REQ);
        mm_A     = acc;
        mm_B     = acc;
      end
      S_MUL_REQ, S_MUL_WAIT: begin
        mm_start = (state == S_MUL_REQ);
        mm_A     = acc;
        mm_B     = base;
      end
      S_FINISH: begin
        done = 1'b1;
        R    = acc;
      end
      default: ;
    endcase
  end

  assign mm_N = mod;

endmodule
